// File: rtl/timer_ctrl.sv
// Memory-mapped prescaled down-counting timer with one-shot / auto-reload modes,
// a sticky write-1-to-clear expiry flag and a level interrupt.
module timer_ctrl #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs_timer_n,
    input  logic        mem_write,
    input  logic [3:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data_timer,
    output logic        timer_irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic               ctrl_en;
    logic               ctrl_auto_reload;
    logic               ctrl_irq_en;
    logic [PRESC_W-1:0] ctrl_prescale;
    logic [CNT_W-1:0]   load_q;
    logic [CNT_W-1:0]   count_q;
    logic               expired_q;
    logic [PRESC_W-1:0] psc_q;

    // Bus decode
    logic [1:0]         reg_sel;
    logic               bus_wr;
    logic               wr_ctrl;
    logic               wr_load;
    logic               wr_count;
    logic               wr_status;
    logic [PRESC_W-1:0] wr_prescale;

    // Byte lanes within a word are not decoded; full-word accesses only.
    logic               unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    assign reg_sel     = addr[3:2];
    assign bus_wr      = !cs_timer_n && mem_write;
    assign wr_ctrl     = bus_wr && (reg_sel == REG_CTRL);
    assign wr_load     = bus_wr && (reg_sel == REG_LOAD);
    assign wr_count    = bus_wr && (reg_sel == REG_COUNT);
    assign wr_status   = bus_wr && (reg_sel == REG_STATUS);
    assign wr_prescale = write_data[8 +: PRESC_W];

    // Tick and expiry qualification
    logic tick;
    logic count_zero;
    logic expire;
    logic psc_restart;

    assign tick       = ctrl_en && (psc_q == ctrl_prescale);
    assign count_zero = (count_q == '0);
    // A COUNT store consumes the tick, so a concurrent store suppresses expiry.
    assign expire     = tick && count_zero && !wr_count;

    // Changing the divide ratio or disabling restarts the prescaler phase.
    assign psc_restart = wr_ctrl && ((wr_prescale != ctrl_prescale) || !write_data[0]);

    // NOTE: reset is sampled on the clock edge (synchronous), so reset_n is not
    // in the sensitivity list and every state register is cleared inside the block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            psc_q <= '0;
        end else if (!ctrl_en || tick || psc_restart) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_q + PRESC_ONE;
        end
    end

    // NOTE: non-blocking assignments only in sequential logic; when two
    // assignments to one register fire in the same edge, the later one wins,
    // which is how the one-shot clear of EN overrides a CTRL store below.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_en          <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            ctrl_prescale    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en          <= write_data[0];
                ctrl_auto_reload <= write_data[1];
                ctrl_irq_en      <= write_data[2];
                ctrl_prescale    <= wr_prescale;
            end
            if (expire && !ctrl_auto_reload) begin
                ctrl_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_q <= '0;
        end else if (wr_load) begin
            load_q <= write_data[CNT_W-1:0];
        end
    end

    // Reload samples load_q before a concurrent LOAD store lands.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= write_data[CNT_W-1:0];
        end else if (tick) begin
            if (!count_zero) begin
                count_q <= count_q - CNT_ONE;
            end else if (ctrl_auto_reload) begin
                count_q <= load_q;
            end
        end
    end

    // Hardware set has priority over software write-1-to-clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            expired_q <= 1'b0;
        end else if (expire) begin
            expired_q <= 1'b1;
        end else if (wr_status && write_data[0]) begin
            expired_q <= 1'b0;
        end
    end

    // NOTE: the read mux defaults to zero before the case so no path leaves the
    // output unassigned, which would otherwise infer a latch.
    always_comb begin
        read_data_timer = '0;
        if (!cs_timer_n) begin
            case (reg_sel)
                REG_CTRL: begin
                    read_data_timer[0]             = ctrl_en;
                    read_data_timer[1]             = ctrl_auto_reload;
                    read_data_timer[2]             = ctrl_irq_en;
                    read_data_timer[8 +: PRESC_W]  = ctrl_prescale;
                end
                REG_LOAD:   read_data_timer[CNT_W-1:0] = load_q;
                REG_COUNT:  read_data_timer[CNT_W-1:0] = count_q;
                REG_STATUS: read_data_timer[0]         = expired_q;
                default:    read_data_timer            = '0;
            endcase
        end
    end

    assign timer_irq = expired_q && ctrl_irq_en;

endmodule
